// File: rtl/vga_sync_detector.sv
// vga_sync_detector: recovers VGA timing from incoming sync pulses,
// measures line/frame geometry and flags frame-stable lock.
module vga_sync_detector #(
  parameter int CNT_W       = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_len,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_len,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             lock_lost
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic [MW-1:0]    match_cnt, match_n;
  logic [CNT_W-1:0] v_total_n;
  logic [CNT_W-1:0] hs_cnt, vs_cnt;
  logic [CNT_W-1:0] line_len, frame_cnt;
  logic             hs1, hs2, hs3;
  logic             vs1, vs2, vs3;
  logic             h_rise, h_fall;
  logic             v_rise, v_fall;
  logic             line_ok, line_ok_now;
  logic             h_bad, v_match;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {hs3, hs2, hs1} <= '0;
      {vs3, vs2, vs1} <= '0;
    end else begin
      {hs3, hs2, hs1} <= {hs2, hs1, hsync_in};
      {vs3, vs2, vs1} <= {vs2, vs1, vsync_in};
    end
  end

  assign h_rise = hs2 & ~hs3;
  assign h_fall = ~hs2 & hs3;
  assign v_rise = vs2 & ~vs3;
  assign v_fall = ~vs2 & vs3;

  // A line ending on the frame edge still counts toward the old frame.
  always_comb begin
    line_len    = sat_inc(hpos);
    frame_cnt   = h_rise ? sat_inc(vpos) : vpos;
    h_bad       = h_rise & (line_len != h_total);
    line_ok_now = line_ok & ~h_bad;
    v_match     = line_ok_now & (frame_cnt == v_total);
  end

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    v_total_n = v_total;
    unique case (state)
      SEARCH: begin
        if (v_rise) begin
          v_total_n = '0;
          match_n   = '0;
          state_n   = MEASURE;
        end
      end
      MEASURE: begin
        if (v_rise) begin
          v_total_n = frame_cnt;
          if (v_match) begin
            match_n = match_cnt + 1'b1;
            if (match_n == LOCK_N)
              state_n = LOCKED;
          end else begin
            match_n = '0;
          end
        end
      end
      LOCKED: begin
        if (v_rise)
          v_total_n = frame_cnt;
        if (h_bad
            || (v_rise && frame_cnt != v_total)
            || hpos == CMAX
            || vpos == CMAX)
          state_n = SEARCH;
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos       <= '0;
      vpos       <= '0;
      h_total    <= '0;
      h_sync_len <= '0;
      v_sync_len <= '0;
      hs_cnt     <= '0;
      vs_cnt     <= '0;
      line_ok    <= 1'b1;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hpos <= h_rise ? '0 : sat_inc(hpos);
      if (h_rise)
        h_total <= line_len;
      if (v_rise)
        vpos <= '0;
      else if (h_rise)
        vpos <= sat_inc(vpos);
      if (h_fall) begin
        h_sync_len <= hs_cnt;
        hs_cnt     <= '0;
      end else if (hs2) begin
        hs_cnt <= sat_inc(hs_cnt);
      end
      if (v_fall) begin
        v_sync_len <= vs_cnt;
        vs_cnt     <= '0;
      end else if (vs2 && h_rise) begin
        vs_cnt <= sat_inc(vs_cnt);
      end
      line_ok     <= v_rise ? 1'b1 : line_ok_now;
      line_start  <= h_rise;
      frame_start <= v_rise;
    end
  end

  // locked trails state by one edge; lock_lost marks that falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      match_cnt <= '0;
      v_total   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      v_total   <= v_total_n;
      locked    <= (state == LOCKED);
      lock_lost <= locked & (state != LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_sync_detector.sv
// tb_vga_sync_detector: directed frame table, scoreboard queues
// of expected line/frame responses checked by a negedge monitor.
module tb_vga_sync_detector;

  localparam int H_TOT  = 40;
  localparam int H_SYNC = 5;
  localparam int V_SYNC = 2;
  localparam int CMAX   = 2047;

  typedef struct packed {
    int cyc;
    int prev;
    int htot;
  } ln_t;

  typedef struct packed {
    int htot;
    int vtot;
    int vsl;
    int lk;
    int lost;
  } fr_t;

  typedef struct packed {
    int lines;
    int bad;
    int htot;
    int vtot;
    int vsl;
    int lk;
    int lost;
    int post;
  } row_t;

  logic        clk;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic [10:0] h_total;
  logic [10:0] h_sync_len;
  logic [10:0] v_total;
  logic [10:0] v_sync_len;
  logic        line_start;
  logic        frame_start;
  logic        locked;
  logic        lock_lost;

  int   n_tot = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   lost_cnt = 0;
  int   nxt_prev;
  int   nxt_htot;
  int   prev_hpos = 0;
  bit   fpend = 0;
  ln_t  lq[$];
  fr_t  fq[$];
  row_t tbl [24];
  row_t part;

  vga_sync_detector #(
    .CNT_W(11),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .hpos(hpos),
    .vpos(vpos),
    .h_total(h_total),
    .h_sync_len(h_sync_len),
    .v_total(v_total),
    .v_sync_len(v_sync_len),
    .line_start(line_start),
    .frame_start(frame_start),
    .locked(locked),
    .lock_lost(lock_lost)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic unexpected(input string nm);
    n_tot++;
    $display("FAIL unexpected_%s: got pulse expected none", nm);
  endtask

  task automatic run_line(input int len, input bit vs, input int rst_at);
    ln_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      hsync_in = (i < H_SYNC);
      vsync_in = vs;
      if (i == 0) begin
        e.cyc  = cyc + 3;
        e.prev = nxt_prev;
        e.htot = nxt_htot;
        lq.push_back(e);
      end
      if (i == rst_at) begin
        chk("locked_before_reset", locked, 1);
        reset = 1;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_hpos", hpos, 0);
        chk("async_rst_h_total", h_total, 0);
        chk("async_rst_v_total", v_total, 0);
      end
      if (rst_at >= 0 && i == rst_at + 3)
        reset = 0;
    end
    nxt_prev = (rst_at >= 0) ? -1 : len - 1;
    nxt_htot = (rst_at >= 0) ? -1 : len;
  endtask

  task automatic run_frame(input row_t r, input int first);
    fr_t f;
    if (first == 0) begin
      f.htot = r.htot;
      f.vtot = r.vtot;
      f.vsl  = r.vsl;
      f.lk   = r.lk;
      f.lost = r.lost;
      fq.push_back(f);
    end
    for (int ln = first; ln < r.lines; ln++)
      run_line((ln == r.bad) ? H_TOT + 1 : H_TOT, ln < V_SYNC,
               (r.post == 2 && ln == 5) ? 20 : -1);
    if (r.post == 1) begin
      repeat (2100) begin
        @(negedge clk);
        hsync_in = 0;
        vsync_in = 0;
      end
      nxt_prev = CMAX;
      nxt_htot = CMAX;
    end
  endtask

  // Monitor: frame records are checked one cycle after frame_start
  // so that locked/lock_lost have settled.
  initial begin
    ln_t l;
    fr_t f;
    forever begin
      @(negedge clk);
      if (lock_lost) begin
        lost_cnt++;
        chk("locked_low_at_lock_lost", locked, 0);
      end
      if (fpend) begin
        fpend = 0;
        if (fq.size() == 0) begin
          unexpected("frame_start");
        end else begin
          f = fq.pop_front();
          chk("frame_h_total", h_total, f.htot);
          chk("frame_h_sync_len", h_sync_len, H_SYNC);
          chk("frame_v_total", v_total, f.vtot);
          chk("frame_v_sync_len", v_sync_len, f.vsl);
          chk("frame_locked", locked, f.lk);
          chk("frame_lock_lost_count", lost_cnt, f.lost);
        end
      end
      if (frame_start)
        fpend = 1;
      if (line_start) begin
        if (lq.size() == 0) begin
          unexpected("line_start");
        end else begin
          l = lq.pop_front();
          chk("line_latency_cycle", cyc, l.cyc);
          chk("hpos_at_line_start", hpos, 0);
          if (l.prev >= 0)
            chk("hpos_before_line_start", prev_hpos, l.prev);
          if (l.htot >= 0)
            chk("line_h_total", h_total, l.htot);
        end
      end
      prev_hpos = hpos;
    end
  end

  initial begin
    tbl = '{
      '{25, -1,   40,  0, 0, 0, 0, 0},
      '{25, -1,   40, 25, 2, 0, 0, 0},
      '{25, -1,   40, 25, 2, 0, 0, 0},
      '{25, -1,   40, 25, 2, 1, 0, 0},
      '{25, 10,   40, 25, 2, 1, 0, 0},
      '{25, -1,   40,  0, 2, 0, 1, 0},
      '{25, -1,   40, 25, 2, 0, 1, 0},
      '{25, -1,   40, 25, 2, 0, 1, 0},
      '{25, -1,   40, 25, 2, 1, 1, 0},
      '{24, -1,   40, 25, 2, 1, 1, 0},
      '{25, -1,   40, 24, 2, 0, 2, 0},
      '{25, -1,   40,  0, 2, 0, 2, 0},
      '{25, -1,   40, 25, 2, 0, 2, 0},
      '{25, -1,   40, 25, 2, 0, 2, 0},
      '{25, -1,   40, 25, 2, 1, 2, 1},
      '{25, -1, 2047,  0, 2, 0, 3, 0},
      '{25, -1,   40, 25, 2, 0, 3, 0},
      '{25, -1,   40, 25, 2, 0, 3, 0},
      '{25, -1,   40, 25, 2, 1, 3, 0},
      '{25, -1,   40, 25, 2, 1, 3, 2},
      '{25, -1,   40,  0, 0, 0, 3, 0},
      '{25, -1,   40, 25, 2, 0, 3, 0},
      '{25, -1,   40, 25, 2, 0, 3, 0},
      '{25, -1,   40, 25, 2, 1, 3, 0}
    };
    part = '{25, -1, 0, 0, 0, 0, 0, 0};

    reset    = 0;
    hsync_in = 0;
    vsync_in = 0;
    nxt_prev = -1;
    nxt_htot = -1;
    #2 reset = 1;
    #1;
    chk("reset_hpos", hpos, 0);
    chk("reset_vpos", vpos, 0);
    chk("reset_h_total", h_total, 0);
    chk("reset_v_total", v_total, 0);
    chk("reset_sync_lens", {h_sync_len, v_sync_len}, 0);
    chk("reset_pulses", {line_start, frame_start, lock_lost}, 0);
    chk("reset_locked", locked, 0);

    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("idle_hpos_count", hpos, 5);
    repeat (2100) @(negedge clk);
    chk("idle_hpos_saturated", hpos, CMAX);
    chk("idle_vpos", vpos, 0);
    chk("idle_h_total", h_total, 0);
    chk("idle_v_total", v_total, 0);
    chk("idle_locked", locked, 0);
    chk("idle_lock_lost_count", lost_cnt, 0);
    repeat (20) @(negedge clk);
    chk("idle_hpos_hold", hpos, CMAX);

    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    nxt_prev = -1;
    nxt_htot = -1;
    run_frame(part, 10);
    for (int k = 0; k < 24; k++)
      run_frame(tbl[k], 0);

    repeat (10) @(negedge clk);
    chk("line_queue_drained", lq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    chk("lock_lost_total", lost_cnt, 3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/vga_sync_detector.md
# vga_sync_detector

Receive-side companion to the VGA sync generator. It samples incoming active-high `hsync_in`/`vsync_in` pulses in the pixel-clock domain and measures line length, hsync width, lines per frame and vsync width. It recovers `hpos`/`vpos` counters and asserts `locked` once timing has been stable for a set number of frames. It is used for loopback self-test of the generator and for capturing external video timing.

## Interface
- `CNT_W`, 11: width of all counters and measured values; counters saturate at 2^CNT_W-1.
- `LOCK_FRAMES`, 2: consecutive matching frames required to lock.
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `hsync_in` in 1: horizontal sync, active-high, asynchronous to `clk`.
- `vsync_in` in 1: vertical sync, active-high, asynchronous to `clk`.
- `hpos` out CNT_W: clocks since the last hsync rising edge.
- `vpos` out CNT_W: line_starts since the last frame_start.
- `h_total` out CNT_W: last measured line length, in clocks.
- `h_sync_len` out CNT_W: last measured hsync high time, in clocks.
- `v_total` out CNT_W: last captured frame length, in lines.
- `v_sync_len` out CNT_W: line_starts counted while vsync was high.
- `line_start` out 1: one-cycle pulse on an hsync rising edge.
- `frame_start` out 1: one-cycle pulse on a vsync rising edge.
- `locked` out 1: timing stable.
- `lock_lost` out 1: one-cycle pulse when lock drops.

## Operation

**Input synchronisation and edge detection**
- Each sync input passes through two synchroniser flops (s1, s2), then a third flop (s3) for edge detection.
- Rise = s2 & ~s3. Fall = ~s2 & s3.

**Horizontal measurement**
- `hpos` increments every clock and saturates.
- On a rise: `h_total` <= `hpos`+1, then `hpos` <= 0.
- `h_sync_len` counts clocks while s2 is high and is captured on a fall.

**Vertical measurement**
- `vpos` increments on each `line_start`.
- `v_sync_len` counts line_starts while vsync s2 is high and is captured on a vsync fall.
- If `line_start` and `frame_start` occur in the same cycle, that line belongs to the ending frame: frame count = `vpos`+1, and `vpos` <= 0.
- `line_ok` is set to 1 at `frame_start`.
- `line_ok` is cleared at any `line_start` whose measured length differs from the current `h_total`.

**State machine: SEARCH, MEASURE, LOCKED**
- **SEARCH:** on `frame_start`, set `v_total` <= 0 and `match_cnt` <= 0, then go to MEASURE.
- **MEASURE:** on `frame_start`:
  - If `line_ok` and frame count == `v_total`, increment `match_cnt`; otherwise `match_cnt` <= 0.
  - `v_total` <= frame count in either case.
  - When `match_cnt` reaches `LOCK_FRAMES`, go to LOCKED.
- **LOCKED:** lock is lost on any of:
  - a `line_start` with length != `h_total`;
  - a `frame_start` with frame count != `v_total`;
  - `hpos` or `vpos` saturating.
- On lock loss, pulse `lock_lost` and go to SEARCH. `h_total` and `v_total` still update.
- `locked` = (state == LOCKED), registered.

**Reset**
- All outputs 0, state SEARCH, synchronisers 0, `line_ok` 1, `match_cnt` 0.

## Timing
- Input first sampled high at edge N: `line_start`/`frame_start` is high during the cycle after edge N+2, and `hpos` reads 0 in that same cycle.
- `h_total`, `v_total` and the sync lengths update in the cycle of the corresponding pulse, visible after that edge.
- Stable input, `LOCK_FRAMES`=2: `locked` rises after the 4th `frame_start` following reset or loss. The frame_starts are: SEARCH to MEASURE, mismatch against 0, match 1, match 2.
- `lock_lost` and `locked` falling occur on the same edge, one cycle after the detecting pulse.
- Counter saturation: `hpos` and `vpos` hold at 2047 and never wrap.
- Reset is asynchronous: outputs clear without a clock edge. Deassertion is synchronous to `clk`.

## Test plan
- **Idle after reset, inputs low:** all outputs 0 except `hpos`, which counts 0..2047 and holds. `locked`=0, with no pulses.
- **Nominal timing** (800 clk/line, hsync high 95 clk, 525 lines, vsync high 2 lines; reset released mid-frame): `h_total`=800, `h_sync_len`=95, `v_total`=525, `v_sync_len`=2. `locked`=1 after the 4th `frame_start`, and `lock_lost` never fires.
- **Latency:** `hsync_in` first sampled high at edge N gives `line_start`=1 in the cycle after N+2 with `hpos`=0. `hpos`=799 on the preceding cycle.
- **While locked, one line of 801 clocks:** `lock_lost` pulses once and `locked`=0. `h_total` then reads 801, then 800. Relock occurs at the 4th subsequent `frame_start`.
- **While locked, one frame of 524 lines:** `lock_lost` at that `frame_start`, `v_total`=524. Separately, `hsync_in` held low gives `hpos` saturating at 2047, then `lock_lost`.
- **Asynchronous reset mid-line while locked:** `locked`, `hpos`, `h_total` and `v_total` read 0 before the next `clk` edge, and the lock sequence restarts.
